// File: rtl/ahb_lite_defs.sv
// Shared AHB-Lite definitions for the slave memory and its helpers.
package ahb_lite_defs;

  typedef enum logic [1:0] {
    HtransIdle   = 2'd0,
    HtransBusy   = 2'd1,
    HtransNonseq = 2'd2,
    HtransSeq    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HsizeByte = 3'd0,
    HsizeHalf = 3'd1,
    HsizeWord = 3'd2
  } hsize_t;

  typedef enum logic [2:0] {
    HburstSingle = 3'd0,
    HburstIncr   = 3'd1,
    HburstWrap4  = 3'd2,
    HburstIncr4  = 3'd3,
    HburstWrap8  = 3'd4,
    HburstIncr8  = 3'd5,
    HburstWrap16 = 3'd6,
    HburstIncr16 = 3'd7
  } hburst_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StErr1 = 2'd2,
    StErr2 = 2'd3
  } slave_state_t;

endpackage

// File: rtl/ahb_lite_byte_lane_dec.sv
// Byte-strobe decoder: transfer size plus low address bits to little-endian lane enables.
module ahb_lite_byte_lane_dec
  import ahb_lite_defs::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_i,
  output logic [3:0] strb_o
);

  // Sizes above word select all lanes; callers treat them as word or reject them.
  always_comb begin
    strb_o = 4'b1111;
    case (hsize_i)
      HsizeByte: strb_o = 4'b0001 << addr_i;
      HsizeHalf: strb_o = addr_i[1] ? 4'b1100 : 4'b0011;
      default:   strb_o = 4'b1111;
    endcase
  end

endmodule

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite 32-bit slave memory with programmable wait states and read-after-write forwarding.
// Define AHB_LITE_SLAVE_ERR_EN to enable address/size/alignment checks and the two-cycle
// ERROR response; without it addresses wrap, oversize is treated as word and low bits are masked.
module ahb_lite_slave_mem
  import ahb_lite_defs::*;
#(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam int unsigned ByteRange = 4 * MEM_WORDS;

  htrans_t       trans;
  logic          accept;
  logic          legal_acc;
  logic          addr_err;
  logic [2:0]    eff_size;
  logic [1:0]    eff_lo;
  logic [AW-1:0] idx;
  logic [3:0]    strb;
  logic          commit;
  logic [31:0]   rd_word;

  slave_state_t  state_q;
  logic [3:0]    cnt_q;
  logic          hreadyout_q;
  logic          hresp_q;

  logic          wr_pend_q, wr_pend_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [3:0]    wr_strb_q, wr_strb_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   mem_q [MEM_WORDS];

  // Burst type is irrelevant (every beat is single); upper address bits only matter for checks.
  logic unused_bits;
  assign unused_bits = ^{HBURST, HADDR[31:AW+2]};

  assign trans     = htrans_t'(HTRANS);
  assign accept    = HSEL & HREADY & ((trans == HtransNonseq) | (trans == HtransSeq));
  assign legal_acc = accept & ~addr_err;
  assign idx       = HADDR[AW+1:2];

`ifdef AHB_LITE_SLAVE_ERR_EN
  // Flag out-of-range, oversize and misaligned accesses.
  always_comb begin
    addr_err = (HADDR >= 32'(ByteRange)) | (HSIZE > 3'd2) |
               ((HSIZE == 3'd1) & HADDR[0]) | ((HSIZE == 3'd2) & (|HADDR[1:0]));
    eff_size = HSIZE;
    eff_lo   = HADDR[1:0];
  end
`else
  // No errors: clamp size to word and force natural alignment.
  always_comb begin
    addr_err = 1'b0;
    eff_size = (HSIZE > 3'd2) ? 3'd2 : HSIZE;
    eff_lo   = HADDR[1:0];
    if (eff_size == HsizeHalf) begin
      eff_lo[0] = 1'b0;
    end else if (eff_size == HsizeWord) begin
      eff_lo = 2'b00;
    end
  end
`endif

  ahb_lite_byte_lane_dec u_lane_dec (
    .hsize_i (eff_size),
    .addr_i  (eff_lo),
    .strb_o  (strb)
  );

  // A pending write lands in the cycle its data phase is released.
  assign commit = wr_pend_q & hreadyout_q;

  // Transfer FSM with registered HREADYOUT/HRESP.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      unique case (state_q)
        StIdle, StErr2: begin
          state_q     <= StIdle;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
          if (accept) begin
            if (addr_err) begin
              state_q     <= StErr1;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_ERROR;
            end else if (WAIT_STATES != 0) begin
              state_q     <= StWait;
              cnt_q       <= 4'(WAIT_STATES);
              hreadyout_q <= 1'b0;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd1) begin
            state_q     <= StIdle;
            hreadyout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StErr1: begin
          state_q     <= StErr2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          state_q     <= StIdle;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Pending-write bookkeeping: a new accept replaces a write that commits on the same edge.
  always_comb begin
    wr_pend_d = wr_pend_q;
    wr_idx_d  = wr_idx_q;
    wr_strb_d = wr_strb_q;
    if (commit) begin
      wr_pend_d = 1'b0;
    end
    if (legal_acc) begin
      wr_pend_d = HWRITE;
      wr_idx_d  = idx;
      wr_strb_d = strb;
    end
  end

  // Read word with bytes from a same-edge commit to the same word merged in.
  always_comb begin
    rd_word = mem_q[idx];
    if (commit && (wr_idx_q == idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb_q[b]) begin
          rd_word[8*b +: 8] = HWDATA[8*b +: 8];
        end
      end
    end
    rdata_d = rdata_q;
    if (legal_acc && !HWRITE) begin
      rdata_d = rd_word;
    end
  end

  // Address-phase capture and read data register.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_pend_q <= 1'b0;
      wr_idx_q  <= '0;
      wr_strb_q <= '0;
      rdata_q   <= '0;
    end else begin
      wr_pend_q <= wr_pend_d;
      wr_idx_q  <= wr_idx_d;
      wr_strb_q <= wr_strb_d;
      rdata_q   <= rdata_d;
    end
  end

  // Storage array; not reset, and a reset edge drops any pending write.
  always_ff @(posedge HCLK) begin
    if (!HRESET && commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb_q[b]) begin
          mem_q[wr_idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = rdata_q;

endmodule
